// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM states,
// next-PC select codes, instruction width and the default reset PC.
package pc_fetch_unit_pkg;

  localparam int unsigned InstrWidth = 32;
  localparam logic [InstrWidth-1:0] DefaultResetPc = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StFetch    = 2'b01,
    StRedirect = 2'b10
  } fetch_state_e;

  typedef enum logic [1:0] {
    PcHold   = 2'b00,
    PcIncr   = 2'b01,
    PcTarget = 2'b10
  } pc_sel_e;

  // Branch targets are forced onto a word boundary.
  function automatic logic [InstrWidth-1:0] align_word(input logic [InstrWidth-1:0] addr);
    return addr & ~InstrWidth'(3);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request bus: single-cycle request/ready handshake with
// read data returned in the accepting cycle.
interface pc_fetch_unit_if;
  import pc_fetch_unit_pkg::*;

  logic                  imem_req;
  logic [InstrWidth-1:0] imem_addr;
  logic                  imem_ready;
  logic [InstrWidth-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/pc_fetch_unit_pc_next_sel.sv
// Combinational next-PC mux: hold, sequential increment (modulo 2^32) or the
// word-aligned redirect target.
module pc_next_sel
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned PcStep = 4
) (
  input  logic [InstrWidth-1:0] pc_i,
  input  logic [InstrWidth-1:0] target_i,
  input  pc_sel_e               sel_i,
  output logic [InstrWidth-1:0] pc_next_o
);

  always_comb begin
    pc_next_o = pc_i;
    unique case (sel_i)
      PcHold:   pc_next_o = pc_i;
      PcIncr:   pc_next_o = pc_i + PcStep;
      PcTarget: pc_next_o = align_word(target_i);
      default:  pc_next_o = pc_i;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: PC register, IDLE/FETCH/REDIRECT FSM and IF/ID register.
// Define PC_FETCH_DELAY_SLOT_EN to keep the IF/ID instruction across a branch.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [InstrWidth-1:0] RESET_PC = DefaultResetPc,
  parameter int unsigned           PC_STEP  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  branch_taken,
  input  logic [InstrWidth-1:0] branch_target,
  input  logic                  stall,
  pc_fetch_unit_if.master       imem,
  output logic                  if_valid,
  output logic [InstrWidth-1:0] if_instr,
  output logic [InstrWidth-1:0] if_pc
);

  fetch_state_e          state_q, state_d;
  logic [InstrWidth-1:0] pc_q, pc_d;
  logic                  if_valid_q, if_valid_d;
  logic [InstrWidth-1:0] if_instr_q, if_instr_d;
  logic [InstrWidth-1:0] if_pc_q, if_pc_d;

  logic    req;
  logic    redirect;
  logic    fetch_done;
  pc_sel_e pc_sel;

  // FSM next state and request generation.
  always_comb begin
    state_d  = state_q;
    req      = 1'b0;
    redirect = 1'b0;
    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
      end
      StFetch: begin
        req = !(if_valid_q && stall) && !branch_taken;
        if (branch_taken) begin
          redirect = 1'b1;
          state_d  = StRedirect;
        end
      end
      StRedirect: begin
        redirect = branch_taken;
        state_d  = branch_taken ? StRedirect : StFetch;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // req is already low in a branch cycle, so a ready there is discarded.
  assign fetch_done = req && imem.imem_ready;

  always_comb begin
    pc_sel = PcHold;
    if (redirect) begin
      pc_sel = PcTarget;
    end else if (fetch_done) begin
      pc_sel = PcIncr;
    end
  end

  pc_next_sel #(
    .PcStep(PC_STEP)
  ) u_pc_next_sel (
    .pc_i     (pc_q),
    .target_i (branch_target),
    .sel_i    (pc_sel),
    .pc_next_o(pc_d)
  );

  // IF/ID register next state.
  always_comb begin
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if (redirect) begin
`ifdef PC_FETCH_DELAY_SLOT_EN
      // Delay-slot instruction stays put; ID still consumes it when not stalled.
      if (!stall) begin
        if_valid_d = 1'b0;
      end
`else
      if_valid_d = 1'b0;
`endif
    end else if (fetch_done) begin
      if_valid_d = 1'b1;
      if_instr_d = imem.imem_rdata;
      if_pc_d    = pc_q;
    end else if (if_valid_q && !stall) begin
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;
  assign if_valid       = if_valid_q;
  assign if_instr       = if_instr_q;
  assign if_pc          = if_pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit; memory returns addr ^ 32'h5A5A_0000.
module tb_pc_fetch_unit;

`ifdef PC_FETCH_DELAY_SLOT_EN
  localparam bit DelaySlot = 1'b1;
`else
  localparam bit DelaySlot = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        stall = 1'b0;
  logic        ready = 1'b1;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int errors = 0;
  int checks = 0;

  pc_fetch_unit_if bus();
  assign bus.imem_ready = ready;
  assign bus.imem_rdata = bus.imem_addr ^ 32'h5A5A_0000;

  pc_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .stall        (stall),
    .imem         (bus),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    stall = 1'b0;
    ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    branch_taken = 1'b1;
    branch_target = 32'h0000_0500;
    stall = 1'b1;
    tick();
    tick();
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 00000000", bus.imem_addr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 00000000", if_instr); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 00000000", if_pc); end
  endtask

  task automatic test_idle_branch();
    apply_reset();
    branch_taken = 1'b1;
    branch_target = 32'h0000_0080;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b want 0", bus.imem_req); end
    tick();
    branch_taken = 1'b0;
    #1;
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL idle_br_addr: got %h want 00000000", bus.imem_addr); end
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL idle_br_req: got %b want 1", bus.imem_req); end
    tick();
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL idle_br_ifpc: got %h want 00000000", if_pc); end
    checks++; if (bus.imem_addr !== 32'h4) begin errors++; $display("FAIL idle_br_next: got %h want 00000004", bus.imem_addr); end
  endtask

  task automatic test_sequential();
    apply_reset();
    tick();
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL seq_req1: got %b want 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL seq_addr0: got %h want 00000000", bus.imem_addr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL seq_valid_early: got %b want 0", if_valid); end
    tick();
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL seq_valid: got %b want 1", if_valid); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL seq_ifpc0: got %h want 00000000", if_pc); end
    checks++; if (if_instr !== 32'h5A5A_0000) begin errors++; $display("FAIL seq_instr0: got %h want 5a5a0000", if_instr); end
    checks++; if (bus.imem_addr !== 32'h4) begin errors++; $display("FAIL seq_addr4: got %h want 00000004", bus.imem_addr); end
    tick();
    checks++; if (bus.imem_addr !== 32'h8) begin errors++; $display("FAIL seq_addr8: got %h want 00000008", bus.imem_addr); end
    checks++; if (if_pc !== 32'h4) begin errors++; $display("FAIL seq_ifpc4: got %h want 00000004", if_pc); end
    tick();
    checks++; if (bus.imem_addr !== 32'hC) begin errors++; $display("FAIL seq_addr12: got %h want 0000000c", bus.imem_addr); end
    checks++; if (if_instr !== 32'h5A5A_0008) begin errors++; $display("FAIL seq_instr8: got %h want 5a5a0008", if_instr); end
  endtask

  task automatic test_wait_states();
    apply_reset();
    tick();
    tick();
    tick();
    ready = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL wait_req0: got %b want 1", bus.imem_req); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.imem_addr !== 32'h8) begin errors++; $display("FAIL wait_addr[%0d]: got %h want 00000008", i, bus.imem_addr); end
      checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL wait_req[%0d]: got %b want 1", i, bus.imem_req); end
      checks++; if (if_instr !== 32'h5A5A_0004) begin errors++; $display("FAIL wait_instr[%0d]: got %h want 5a5a0004", i, if_instr); end
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL wait_valid[%0d]: got %b want 0", i, if_valid); end
    end
    ready = 1'b1;
    tick();
    checks++; if (if_instr !== 32'h5A5A_0008) begin errors++; $display("FAIL wait_instr_rdy: got %h want 5a5a0008", if_instr); end
    checks++; if (if_pc !== 32'h8) begin errors++; $display("FAIL wait_ifpc_rdy: got %h want 00000008", if_pc); end
    checks++; if (bus.imem_addr !== 32'hC) begin errors++; $display("FAIL wait_addr_rdy: got %h want 0000000c", bus.imem_addr); end
  endtask

  task automatic test_stall();
    apply_reset();
    tick();
    tick();
    stall = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_req: got %b want 0", bus.imem_req); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d]: got %b want 0", i, bus.imem_req); end
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", i, if_valid); end
      checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL stall_ifpc[%0d]: got %h want 00000000", i, if_pc); end
      checks++; if (if_instr !== 32'h5A5A_0000) begin errors++; $display("FAIL stall_instr[%0d]: got %h want 5a5a0000", i, if_instr); end
      checks++; if (bus.imem_addr !== 32'h4) begin errors++; $display("FAIL stall_addr[%0d]: got %h want 00000004", i, bus.imem_addr); end
    end
    stall = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL stall_resume_req: got %b want 1", bus.imem_req); end
    tick();
    checks++; if (if_pc !== 32'h4) begin errors++; $display("FAIL stall_resume_ifpc: got %h want 00000004", if_pc); end
    checks++; if (bus.imem_addr !== 32'h8) begin errors++; $display("FAIL stall_resume_addr: got %h want 00000008", bus.imem_addr); end
  endtask

  task automatic test_branch();
    apply_reset();
    for (int i = 0; i < 5; i++) tick();
    checks++; if (bus.imem_addr !== 32'h10) begin errors++; $display("FAIL br_pre_addr: got %h want 00000010", bus.imem_addr); end
    branch_taken = 1'b1;
    branch_target = 32'h0000_0103;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL br_req: got %b want 0", bus.imem_req); end
    tick();
    branch_taken = 1'b0;
    #1;
    checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL br_addr: got %h want 00000100", bus.imem_addr); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL br_bubble: got %b want 0", bus.imem_req); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL br_valid: got %b want 0", if_valid); end
    tick();
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL br_tgt_req: got %b want 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL br_tgt_addr: got %h want 00000100", bus.imem_addr); end
    tick();
    checks++; if (if_pc !== 32'h100) begin errors++; $display("FAIL br_tgt_ifpc: got %h want 00000100", if_pc); end
    checks++; if (if_instr !== 32'h5A5A_0100) begin errors++; $display("FAIL br_tgt_instr: got %h want 5a5a0100", if_instr); end
  endtask

  task automatic test_branch_stall_wrap();
    apply_reset();
    tick();
    tick();
    branch_taken = 1'b1;
    stall = 1'b1;
    ready = 1'b1;
    branch_target = 32'h0000_0040;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL bs_req: got %b want 0", bus.imem_req); end
    tick();
    checks++; if (bus.imem_addr !== 32'h40) begin errors++; $display("FAIL bs_addr: got %h want 00000040", bus.imem_addr); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL bs_ifpc: got %h want 00000000", if_pc); end
    checks++; if (if_instr !== 32'h5A5A_0000) begin errors++; $display("FAIL bs_instr: got %h want 5a5a0000", if_instr); end
    checks++; if (if_valid !== DelaySlot) begin errors++; $display("FAIL bs_valid: got %b want %b", if_valid, DelaySlot); end
    // Re-target while in REDIRECT, to the top word of the address space.
    stall = 1'b0;
    branch_target = 32'hFFFF_FFFE;
    tick();
    branch_taken = 1'b0;
    #1;
    checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL rt_addr: got %h want fffffffc", bus.imem_addr); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rt_bubble: got %b want 0", bus.imem_req); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rt_valid: got %b want 0", if_valid); end
    tick();
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL wrap_req: got %b want 1", bus.imem_req); end
    tick();
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want 00000000", bus.imem_addr); end
    checks++; if (if_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_ifpc: got %h want fffffffc", if_pc); end
    checks++; if (if_instr !== 32'hA5A5_FFFC) begin errors++; $display("FAIL wrap_instr: got %h want a5a5fffc", if_instr); end
  endtask

  task automatic test_reset_mid_fetch();
    apply_reset();
    for (int i = 0; i < 4; i++) tick();
    checks++; if (bus.imem_addr !== 32'hC) begin errors++; $display("FAIL mid_pre_addr: got %h want 0000000c", bus.imem_addr); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL mid_req: got %b want 0", bus.imem_req); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", if_valid); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL mid_addr: got %h want 00000000", bus.imem_addr); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL mid_ifpc: got %h want 00000000", if_pc); end
  endtask

  initial begin
    test_reset();
    test_idle_branch();
    test_sequential();
    test_wait_states();
    test_stall();
    test_branch();
    test_branch_stall_wrap();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
